// File: rtl/avalon_pio_pkg.sv
// Avalon PIO with interrupt: shared register map and mode constants.
// Imported by the top and by the synchroniser/edge sub-module.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, delay stage and primed edge qualifier.
// Edges are masked until the chain has flushed post-reset state.
module pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_data,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam logic [2:0] PRIME_N = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] dly_q;
  logic [WIDTH-1:0] qual;
  logic [2:0]       prime_q;
  logic             primed;

  assign primed = (prime_q == PRIME_N);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      dly_q   <= '0;
      prime_q <= '0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      dly_q <= sync_q[SYNC_STAGES-1];
      if (!primed)
        prime_q <= prime_q + 3'd1;
    end
  end

  assign sync_data = sync_q[SYNC_STAGES-1];

  always_comb begin
    qual = '0;
    unique case (EDGE_TYPE)
      EDGE_FALLING: qual = ~sync_data & dly_q;
      EDGE_ANY:     qual = sync_data ^ dly_q;
      default:      qual = sync_data & ~dly_q;
    endcase
  end

  assign edge_pulse = primed ? qual : '0;

endmodule

// File: rtl/avalon_pio_irq.sv
// Avalon-MM parallel I/O port with direction, set/clear and
// edge-capture or level interrupt.
module avalon_pio_irq
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               IRQ_TYPE    = 1,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;
  logic             irq_q;

  logic [WIDTH-1:0] sync_data;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] irq_src;
  logic [WIDTH-1:0] rd;
  logic             unused_wdata;

  logic wr_en;
  logic wr_data;
  logic wr_dir;
  logic wr_mask;
  logic wr_cap;
  logic wr_set;
  logic wr_clr;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (in_port),
    .sync_data (sync_data),
    .edge_pulse(edge_pulse)
  );

  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  assign wr_en   = chipselect & ~write_n;
  assign wr_data = wr_en && (address == ADDR_DATA);
  assign wr_dir  = wr_en && (address == ADDR_DIR);
  assign wr_mask = wr_en && (address == ADDR_IRQMASK);
  assign wr_cap  = wr_en && (address == ADDR_EDGECAP);
  assign wr_set  = wr_en && (address == ADDR_OUTSET);
  assign wr_clr  = wr_en && (address == ADDR_OUTCLEAR);

  // a new edge wins over a W1C on the same bit
  assign cap_next = (cap_q & ~(wr_cap ? wdata : '0)) | edge_pulse;

  assign irq_src = (IRQ_TYPE == IRQ_EDGE) ? (cap_q & mask_q)
                                          : (sync_data & mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= RESET_VALUE;
      oe_q   <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        wr_data: out_q <= wdata;
        wr_set:  out_q <= out_q | wdata;
        wr_clr:  out_q <= out_q & ~wdata;
        default: ;
      endcase
      if (wr_dir)
        oe_q <= wdata;
      if (wr_mask)
        mask_q <= wdata;
      cap_q <= cap_next;
      irq_q <= |irq_src;
    end
  end

  always_comb begin
    rd = '0;
    unique case (address)
      ADDR_DATA:    rd = sync_data;
      ADDR_DIR:     rd = oe_q;
      ADDR_IRQMASK: rd = mask_q;
      ADDR_EDGECAP: rd = cap_q;
      default:      rd = '0;
    endcase
  end

  assign readdata = 32'(rd);
  assign out_port = out_q;
  assign out_oe   = oe_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_irq.sv
// Directed bench for avalon_pio_irq: edge-IRQ instance plus
// a level-IRQ instance, hand-computed expectations.
module tb_avalon_pio_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs;
  logic        cs_b;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata_b;
  logic [7:0]  in_port;
  logic [7:0]  in_b;
  logic [7:0]  out_port;
  logic [7:0]  out_port_b;
  logic [7:0]  out_oe;
  logic [7:0]  out_oe_b;
  logic        irq;
  logic        irq_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  avalon_pio_irq #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0),
    .IRQ_TYPE(1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .in_port(in_port), .out_port(out_port),
    .out_oe(out_oe), .irq(irq)
  );

  avalon_pio_irq #(
    .WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(0),
    .IRQ_TYPE(0), .SYNC_STAGES(2)
  ) dut_lvl (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs_b), .write_n(write_n), .writedata(writedata),
    .readdata(readdata_b), .in_port(in_b), .out_port(out_port_b),
    .out_oe(out_oe_b), .irq(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel_b, input logic [2:0] a,
                    input logic [31:0] d);
    address   = a;
    writedata = d;
    cs        = ~sel_b;
    cs_b      = sel_b;
    write_n   = 1'b0;
    @(posedge clk);
    #1;
    cs      = 1'b0;
    cs_b    = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  logic [31:0] v;

  initial begin
    reset_n   = 1'b1;
    address   = 3'd0;
    cs        = 1'b0;
    cs_b      = 1'b0;
    write_n   = 1'b1;
    writedata = 32'd0;
    in_port   = 8'hFF;
    in_b      = 8'h00;
    #2 reset_n = 1'b0;
    #1;
    check("rst_out", 32'(out_port), 32'hA5);
    check("rst_oe", 32'(out_oe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // write attempted during reset must not land
    wr(1'b0, 3'd0, 32'h55);
    check("rst_wr", 32'(out_port), 32'hA5);
    step();
    reset_n = 1'b1;
    repeat (5) step();

    rd(3'd0, v); check("data_sync", v, 32'hFF);
    rd(3'd1, v); check("dir_rst", v, 32'h0);
    rd(3'd2, v); check("mask_rst", v, 32'h0);
    rd(3'd3, v); check("cap_prime", v, 32'h0);
    rd(3'd4, v); check("rd_outset", v, 32'h0);
    rd(3'd7, v); check("rd_7", v, 32'h0);
    check("out_rel", 32'(out_port), 32'hA5);
    check("oe_rel", 32'(out_oe), 32'h0);

    wr(1'b0, 3'd2, 32'hFF);
    step(); step();
    check("irq_prime", 32'(irq), 32'h0);
    wr(1'b0, 3'd2, 32'h00);

    // falling edges are not captured in rising mode
    in_port = 8'h00;
    repeat (4) step();
    rd(3'd3, v); check("cap_fall", v, 32'h0);

    wr(1'b0, 3'd0, 32'hFFFF_FF0F);
    check("out_data", 32'(out_port), 32'h0F);
    wr(1'b0, 3'd4, 32'hF0);
    check("out_set", 32'(out_port), 32'hFF);
    wr(1'b0, 3'd5, 32'h03);
    check("out_clr", 32'(out_port), 32'hFC);
    wr(1'b0, 3'd1, 32'hABCD_EF5A);
    check("oe_wr", 32'(out_oe), 32'h5A);
    rd(3'd1, v); check("dir_rd", v, 32'h5A);
    wr(1'b0, 3'd6, 32'hFF);
    check("wr6_ign", 32'(out_port), 32'hFC);
    rd(3'd6, v); check("rd_6", v, 32'h0);

    // rising edge on bit 2: data, capture, irq latency
    wr(1'b0, 3'd2, 32'h04);
    in_port = 8'h04;
    step();
    rd(3'd0, v); check("data_e1", v, 32'h0);
    step();
    rd(3'd0, v); check("data_e2", v, 32'h04);
    rd(3'd3, v); check("cap_e2", v, 32'h0);
    step();
    rd(3'd3, v); check("cap_e3", v, 32'h04);
    check("irq_e3", 32'(irq), 32'h0);
    step();
    check("irq_e4", 32'(irq), 32'h1);
    wr(1'b0, 3'd3, 32'h04);
    check("irq_w1c0", 32'(irq), 32'h1);
    rd(3'd3, v); check("cap_w1c", v, 32'h0);
    step();
    check("irq_w1c1", 32'(irq), 32'h0);

    // set-wins on bit 5
    in_port = 8'h24;
    repeat (4) step();
    rd(3'd3, v); check("cap_b5", v, 32'h20);
    check("irq_unmask", 32'(irq), 32'h0);
    in_port = 8'h04;
    repeat (4) step();
    rd(3'd3, v); check("cap_b5_hold", v, 32'h20);
    in_port = 8'h24;
    step(); step();
    wr(1'b0, 3'd3, 32'h20);
    rd(3'd3, v); check("w1c_setwins", v, 32'h20);
    repeat (3) step();
    wr(1'b0, 3'd3, 32'h20);
    rd(3'd3, v); check("w1c_clear", v, 32'h0);

    // reset mid-operation with a pending interrupt
    in_port = 8'h26;
    wr(1'b0, 3'd2, 32'h02);
    repeat (3) step();
    check("irq_b1", 32'(irq), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_irq", 32'(irq), 32'h0);
    check("mid_out", 32'(out_port), 32'hA5);
    check("mid_oe", 32'(out_oe), 32'h0);
    wr(1'b0, 3'd0, 32'h55);
    check("mid_wr", 32'(out_port), 32'hA5);
    reset_n = 1'b1;
    repeat (5) step();
    rd(3'd3, v); check("mid_cap", v, 32'h0);
    rd(3'd2, v); check("mid_mask", v, 32'h0);
    rd(3'd0, v); check("mid_data", v, 32'h26);
    check("mid_irq2", 32'(irq), 32'h0);

    // level irq: 5-cycle pulse, SYNC_STAGES+1 edge delay
    wr(1'b1, 3'd2, 32'h01);
    in_b = 8'h01;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("lvl_irq_%0d", k), 32'(irq_b),
            (k >= 3 && k <= 7) ? 32'h1 : 32'h0);
      if (k == 5)
        in_b = 8'h00;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
